// File: rtl/mdu_pkg.sv
// Shared types and helpers for the multiply/divide unit.
// MDU_MADD_EN enables the multiply-accumulate op family.
`timescale 1ns/1ps
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } mdu_state_t;

  typedef enum logic [1:0] {
    ACC_SET,
    ACC_ADD,
    ACC_SUB
  } mdu_acc_t;

`ifdef MDU_MADD_EN
  localparam bit MAC_EN = 1'b1;
`else
  localparam bit MAC_EN = 1'b0;
`endif

  function automatic logic is_mac(mdu_op_t op);
    return MAC_EN & (op inside {MDU_MADD, MDU_MADDU,
                                MDU_MSUB, MDU_MSUBU});
  endfunction

  function automatic logic is_mult(mdu_op_t op);
    return (op inside {MDU_MULT, MDU_MULTU}) | is_mac(op);
  endfunction

  function automatic logic is_div(mdu_op_t op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic is_signed(mdu_op_t op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
  endfunction

  function automatic mdu_acc_t acc_of(mdu_op_t op);
    mdu_acc_t r;
    r = ACC_SET;
    if (op inside {MDU_MADD, MDU_MADDU}) r = ACC_ADD;
    if (op inside {MDU_MSUB, MDU_MSUBU}) r = ACC_SUB;
    return r;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage request/response bundle between pipeline and MDU.
// Pipeline side is master, MDU side is slave.
`timescale 1ns/1ps
interface mdu_if;
  import mdu_pkg::*;

  logic        start;
  mdu_op_t     op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, req,
    input  busy, rdata, hi, lo
  );

  modport slave (
    input  start, op, a, b, req,
    output busy, rdata, hi, lo
  );

endinterface

// File: rtl/mdu_core.sv
// Combinational 64-bit product and quotient/remainder datapath.
// Divide-by-zero returns the current HI/LO so the commit is a no-op.
`timescale 1ns/1ps
module mdu_core
  import mdu_pkg::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] ph,
  output logic [31:0] pl
);

  logic        sgn;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] prod;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] q;
  logic [31:0] r;

  always_comb begin
    sgn   = is_signed(op);
    neg_a = sgn & a[31];
    neg_b = sgn & b[31];
    prod  = {{32{neg_a}}, a} * {{32{neg_b}}, b};

    // magnitude divide; MIN/-1 wraps back to MIN with rem 0
    ua = neg_a ? -a : a;
    ub = neg_b ? -b : b;
    uq = '0;
    ur = '0;
    if (b != '0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    q = (neg_a ^ neg_b) ? -uq : uq;
    r = neg_a ? -ur : ur;

    {ph, pl} = prod;
    if (is_div(op)) begin
      if (b == '0) {ph, pl} = {hi, lo};
      else         {ph, pl} = {r, q};
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency FSM plus HI/LO.
// MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU accumulate at completion.
`timescale 1ns/1ps
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic rst_n,
  mdu_if.slave bus
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LAT = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LAT = CW'(DIV_CYCLES - 1);

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   ph_q, ph_d;
  logic [31:0]   pl_q, pl_d;
  logic [31:0]   ph_c, pl_c;
  logic [63:0]   sum;
  logic          go;
`ifdef MDU_MADD_EN
  mdu_acc_t      acc_q, acc_d;
`endif

  mdu_core u_core (
    .op (bus.op),
    .a  (bus.a),
    .b  (bus.b),
    .hi (hi_q),
    .lo (lo_q),
    .ph (ph_c),
    .pl (pl_c)
  );

  always_comb begin
`ifdef MDU_MADD_EN
    unique case (acc_q)
      ACC_ADD: sum = {hi_q, lo_q} + {ph_q, pl_q};
      ACC_SUB: sum = {hi_q, lo_q} - {ph_q, pl_q};
      default: sum = {ph_q, pl_q};
    endcase
`else
    sum = {ph_q, pl_q};
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
`ifdef MDU_MADD_EN
    acc_d   = acc_q;
`endif
    go = bus.start & ~bus.req
       & (is_mult(bus.op) | is_div(bus.op));

    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          ph_d    = ph_c;
          pl_d    = pl_c;
          state_d = ST_BUSY;
          unique case (1'b1)
            is_div(bus.op): cnt_d = DIV_LAT;
            default:        cnt_d = MUL_LAT;
          endcase
`ifdef MDU_MADD_EN
          acc_d = acc_of(bus.op);
`endif
        end else if (!bus.req) begin
          if (bus.op == MDU_MTHI) hi_d = bus.a;
          if (bus.op == MDU_MTLO) lo_d = bus.a;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d        = '0;
          state_d      = ST_IDLE;
          {hi_d, lo_d} = sum;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
`ifdef MDU_MADD_EN
      acc_q   <= ACC_SET;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign bus.busy  = (state_q == ST_BUSY);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.rdata = (bus.op == MDU_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Randomized bench for mdu_unit against a cycle-level arithmetic model.
// Directed literal cases pin the model; MDU_MADD_EN selects the MAC variant.
`timescale 1ns/1ps
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MAC = 1'b1;
`else
  localparam bit MAC = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_if bus();

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;
  int          m_kind;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit m_starts(mdu_op_t op);
    if (op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU})
      return 1'b1;
    if (op inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU})
      return MAC;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_calc(mdu_op_t op,
      logic [31:0] a, logic [31:0] b,
      logic [31:0] hi, logic [31:0] lo);
    int ia, ib;
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] qv, rv;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = a;  ub = b;
    case (op)
      MDU_MULT, MDU_MADD, MDU_MSUB: return sa * sb;
      MDU_MULTU, MDU_MADDU, MDU_MSUBU: return ua * ub;
      MDU_DIV: begin
        if (b == 0) return {hi, lo};
        sq = sa / sb; sr = sa % sb;
        qv = sq; rv = sr;
        return {rv[31:0], qv[31:0]};
      end
      MDU_DIVU: begin
        if (b == 0) return {hi, lo};
        qv = ua / ub; rv = ua % ub;
        return {rv[31:0], qv[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // reference model, one architectural step per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_res = 0;
      m_left = 0; m_kind = 0;
    end else if (m_left > 0) begin
      chk("quiet_while_busy",
          {bus.start, bus.op inside {MDU_MTHI, MDU_MTLO}}, 0);
      m_left--;
      if (m_left == 0) begin
        case (m_kind)
          1: {m_hi, m_lo} = {m_hi, m_lo} + m_res;
          2: {m_hi, m_lo} = {m_hi, m_lo} - m_res;
          default: {m_hi, m_lo} = m_res;
        endcase
      end
    end else if (!bus.req) begin
      if (bus.start && m_starts(bus.op)) begin
        m_res  = m_calc(bus.op, bus.a, bus.b, m_hi, m_lo);
        m_left = (bus.op inside {MDU_DIV, MDU_DIVU}) ? DC : MC;
        m_kind = 0;
        if (bus.op inside {MDU_MADD, MDU_MADDU}) m_kind = 1;
        if (bus.op inside {MDU_MSUB, MDU_MSUBU}) m_kind = 2;
      end else if (bus.op == MDU_MTHI) begin
        m_hi = bus.a;
      end else if (bus.op == MDU_MTLO) begin
        m_lo = bus.a;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("busy", bus.busy, m_left > 0);
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
      chk("rdata", bus.rdata,
          (bus.op == MDU_MFHI) ? m_hi : m_lo);
    end
  end

  task automatic drive(bit s, mdu_op_t op,
                       logic [31:0] a, logic [31:0] b, bit rq);
    @(negedge clk); #1;
    bus.start = s; bus.op = op;
    bus.a = a; bus.b = b; bus.req = rq;
  endtask

  task automatic set_idle();
    bus.start = 0; bus.op = MDU_NONE;
    bus.a = 0; bus.b = 0; bus.req = 0;
  endtask

  // issue one op, then count busy cycles (bounded)
  task automatic run(bit s, mdu_op_t op, logic [31:0] a,
                     logic [31:0] b, bit rq, output int n);
    drive(s, op, a, b, rq);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else begin
        #1 set_idle();
        break;
      end
      #1 set_idle();
    end
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int k;
    mdu_op_t op;
    set_idle();
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    #1 rst_n = 1;
    cmp_en = 1;

    run(1, MDU_MULT, 32'hFFFF_FFFD, 7, 0, n);
    chk("mult_len", n, 5);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
    drive(0, MDU_MFLO, 0, 0, 0);
    #1 chk("mflo", bus.rdata, 32'hFFFF_FFEB);

    run(1, MDU_DIVU, 100, 7, 0, n);
    chk("divu_len", n, 10);
    chk("divu_lo", bus.lo, 14);
    chk("divu_hi", bus.hi, 2);
    run(1, MDU_DIV, 32'hFFFF_FFF9, 2, 0, n);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);

    drive(0, MDU_MTHI, 32'h11, 0, 0);
    drive(0, MDU_MTLO, 32'h22, 0, 0);
    run(1, MDU_DIV, 5, 0, 0, n);
    chk("div0_len", n, 10);
    chk("div0_hi", bus.hi, 32'h11);
    chk("div0_lo", bus.lo, 32'h22);

    run(1, MDU_MULT, 2, 3, 1, n);
    chk("req_start_len", n, 0);
    chk("req_start_hi", bus.hi, 32'h11);
    chk("req_start_lo", bus.lo, 32'h22);
    drive(0, MDU_MTLO, 5, 0, 1);
    drive(0, MDU_NONE, 0, 0, 0);
    chk("req_mtlo", bus.lo, 32'h22);

    run(1, MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, n);
    chk("ovf_len", n, 10);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 0);

    drive(0, MDU_MTHI, 32'hDEAD, 0, 0);
    drive(0, MDU_MFHI, 0, 0, 0);
    #1 chk("mfhi", bus.rdata, 32'hDEAD);

    drive(1, MDU_DIV, 100, 3, 0);
    @(negedge clk); #1 set_idle();
    repeat (2) @(negedge clk);
    #1 chk("div_busy_pre_rst", bus.busy, 1);
    rst_n = 0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    @(negedge clk); #1 rst_n = 1;

    drive(0, MDU_MTHI, 0, 0, 0);
    drive(0, MDU_MTLO, 10, 0, 0);
    run(1, MDU_MADD, 3, 4, 0, n);
    chk("madd_len", n, MAC ? 5 : 0);
    chk("madd_lo", bus.lo, MAC ? 22 : 10);
    chk("madd_hi", bus.hi, 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      bus.req = ($urandom_range(0, 9) == 0);
      bus.a = rand_opnd();
      bus.b = rand_opnd();
      if (m_left > 0) begin
        k = $urandom_range(0, 2);
        op = (k == 0) ? MDU_NONE : (k == 1) ? MDU_MFHI : MDU_MFLO;
        bus.start = 0;
      end else begin
        k = $urandom_range(0, 12);
        op = mdu_op_t'(k);
        bus.start = (k inside {[1:4], [9:12]});
      end
      bus.op = op;
    end
    drive(0, MDU_NONE, 0, 0, 0);
    repeat (DC + 3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
